vga_line_fetch: RTL
===================

# vga_line_fetch

Line-buffer fetch controller between the frame store and the VGA timing generator. It prefetches each active video line from a burst-read memory port into a ping-pong pair of line buffers. It then serves `pix_data` to the timing generator from the buffer matching the requested `pix_y`, one cycle after the `pix_x`/`pix_y` request. Memory port and display run on the single pixel clock.

## Interface
- `H_VALID`, 640: active pixels per line; must be a multiple of `BURST_LEN`.
- `V_VALID`, 480: active lines per frame.
- `BURST_LEN`, 64: words per memory read burst.
- `ADDR_W`, 19: memory word-address width.
- `UNDERRUN_COLOR`, 16'hF800: pixel value driven when the requested line is not ready.
- `vga_clk` in 1: pixel clock; all logic is on its rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `vsync` in 1: active-high frame sync from the timing generator.
- `pix_x` in 10: requested column; 10'h3ff means no request.
- `pix_y` in 10: requested row; 10'h3ff means no request.
- `pix_data` out 16: RGB565 pixel, registered.
- `rd_req` out 1: burst read request.
- `rd_addr` out ADDR_W: burst start word address; stable while `rd_req` is high.
- `rd_ack` in 1: memory accepts the request.
- `rd_data_valid` in 1: one read word is present on `rd_data`.
- `rd_data` in 16: read data.
- `underrun` out 1: sticky error flag; cleared at frame start.

## Operation
- Storage: two buffers, `buf[0]` and `buf[1]`, each `H_VALID`×16. Line y is stored in `buf[y[0]]`. Each buffer has a ready flag, `buf_ok[b]`.
- Frame trigger: rising edge of `vsync`, detected against a registered copy. It starts a fetch of line 0, sets the line base address to 0, and clears `underrun`.
- Line trigger: a cycle with `pix_x==0` and `pix_y!=10'h3ff`. It starts a fetch of line `pix_y+1` if `pix_y+1 < V_VALID`; otherwise it does nothing.
- Line base address: accumulated by adding `H_VALID` per fetched line; no multiplier. Burst address = base + word offset, truncated to `ADDR_W` bits.
- Fetch FSM states:
  - IDLE: wait for a trigger.
  - REQ: `rd_req=1` with `rd_addr` held; on `rd_ack=1` go to RECV.
  - RECV: each `rd_data_valid` beat is written to the target buffer at the word offset, which then increments. After `BURST_LEN` beats go to NEXT.
  - NEXT: 1 cycle. If the offset equals `H_VALID`, set `buf_ok` for the target buffer, advance the base, and go to IDLE (or straight to REQ if a fetch is pending). Otherwise go to REQ.
- Starting a fetch clears `buf_ok` for its target buffer.
- Trigger while a fetch is in progress: the trigger is latched into one pending slot. The current burst is never aborted.
  - A frame trigger pending takes priority. The in-flight line is discarded at NEXT (its `buf_ok` is not set), and the line-0 fetch begins.
  - A second trigger while the slot is already occupied overwrites the slot and sets `underrun`.
- `rd_data_valid` outside RECV is ignored.
- Pixel output, one register stage:
  - `pix_x==10'h3ff` or `pix_y==10'h3ff`: `pix_data` = 0.
  - Otherwise, if `buf_ok[pix_y[0]]` is set: `pix_data` = `buf[pix_y[0]][pix_x]`.
  - Otherwise: `pix_data` = `UNDERRUN_COLOR` and `underrun` is set.
- Reset values: `pix_data=0`, `rd_req=0`, `rd_addr=0`, `underrun=0`, FSM=IDLE, `buf_ok=2'b00`, pending slot empty, base=0, offset=0.
- Reset mid-burst returns the block to IDLE immediately. The memory side must tolerate the abandoned burst.

## Timing
- Pixel read latency: `pix_data` is valid exactly 1 cycle after `pix_x`/`pix_y` are presented. This matches a timing generator that requests 1 cycle ahead of its valid window.
- Trigger to request: `rd_req` rises on the edge after the trigger cycle.
- Request handshake: `rd_req` drops on the edge where `rd_ack` is sampled high. `rd_ack` may arrive in the same cycle `rd_req` rises.
- Beat handling: back-to-back `rd_data_valid` beats are accepted at 1 word per clock.
- NEXT adds 1 dead cycle per burst.
- A line must finish in fewer than `H_TOTAL` clocks (800 at 640×480) including memory latency; otherwise `underrun` is set.
- Line reuse: a buffer read on line y is not overwritten until the line y+1 trigger, which fetches line y+2 into that buffer.

## Test plan
- Reset, then release with no stimulus: `pix_data=0`, `rd_req=0`, `underrun=0`, and both `buf_ok` flags clear.
- Frame trigger with `rd_ack` returned 1 cycle after `rd_req` and continuous `rd_data=addr[15:0]`: 10 bursts at `rd_addr` 0, 64, …, 576 are issued and `buf_ok[0]` is set. Then `pix_y=0`, `pix_x=5` gives `pix_data=16'd5` on the next cycle.
- Full-frame run at 640×480 timing with 3-cycle ack latency: the line-1 fetch uses addresses starting at 640, and the line-479 fetch at 306560. No fetch is issued after line 479, and `underrun` stays 0.
- Memory stalled (`rd_ack` held low) through line 1: the pixel at `pix_y=1`, `pix_x=0` reads 16'hF800 and `underrun` goes to 1. The next `vsync` rise clears `underrun`.
- `vsync` rises during the RECV state of the line-200 fetch: the current burst completes, the line-200 buffer stays not-ok, and the next `rd_addr` is 0.
- Inject spurious `rd_data_valid` beats in IDLE: no buffer contents change.

Source files
------------

// File: rtl/vga_line_fetch_if.sv
// vga_line_fetch_if
//   Bundles the two bus-style connections of the line fetcher:
//     - pixel port to the VGA timing generator: pix_x / pix_y request,
//       pix_data answer one clock later
//     - burst-read port to the frame store: rd_req / rd_addr / rd_ack
//       request handshake, rd_data_valid / rd_data read beats
//   master : the line fetcher (drives pix_data, rd_req, rd_addr)
//   slave  : the timing generator + memory side
interface vga_line_fetch_if #(
    parameter int ADDR_W = 19
);
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic [15:0]       pix_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_data_valid;
    logic [15:0]       rd_data;

    modport master (
        input  pix_x, pix_y, rd_ack, rd_data_valid, rd_data,
        output pix_data, rd_req, rd_addr
    );

    modport slave (
        output pix_x, pix_y, rd_ack, rd_data_valid, rd_data,
        input  pix_data, rd_req, rd_addr
    );
endinterface

// File: rtl/vga_line_fetch.sv
// vga_line_fetch
//   Prefetches active video lines from a burst-read frame store into a
//   ping-pong pair of line buffers (line y lives in buffer y[0]) and serves
//   pixels to the timing generator one clock after each pix_x/pix_y request.
// Ports:
//   vga_clk   - pixel clock, everything on its rising edge
//   sys_rst_n - asynchronous active-low reset
//   vsync     - active-high frame sync; its rising edge restarts at line 0
//   underrun  - sticky error flag, cleared on each vsync rising edge
//   bus       - pixel request/answer and burst-read memory port (master side)
module vga_line_fetch #(
    parameter int          H_VALID        = 640,
    parameter int          V_VALID        = 480,
    parameter int          BURST_LEN      = 64,
    parameter int          ADDR_W         = 19,
    parameter logic [15:0] UNDERRUN_COLOR = 16'hF800
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic             vsync,
    output logic             underrun,
    vga_line_fetch_if.master bus
);
    localparam int         OFF_W  = $clog2(H_VALID + 1);
    localparam int         IDX_W  = $clog2(H_VALID);
    localparam int         BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [9:0] NO_REQ = 10'h3ff;

    typedef enum logic [1:0] {IDLE, REQ, RECV, NEXT} state_t;

    state_t            state;
    logic              vsync_q;
    logic [1:0]        buf_ok;
    logic              pend_vld;
    logic              pend_frame;
    logic              pend_buf;
    logic              tgt_buf;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [OFF_W-1:0]  offset;
    logic [BEAT_W-1:0] beat;
    logic              rd_req_q;
    logic [15:0]       pix_data_p1;
    logic [15:0]       line_buf [2][H_VALID];

    logic              frame_trig;
    logic              line_trig;
    logic              trig;
    logic              trig_buf;
    logic              pix_req;
    logic              line_done;
    logic              beat_last;
    logic              pend_take;
    logic              wr_en;
    logic [ADDR_W-1:0] base_next;

    assign frame_trig = vsync & ~vsync_q;
    // The request for column 0 of line y kicks off the fetch of line y+1;
    // there is nothing to fetch after the last active line.
    assign line_trig  = (bus.pix_x == 10'd0) && (bus.pix_y != NO_REQ) &&
                        (({1'b0, bus.pix_y} + 11'd1) < 11'(V_VALID));
    assign trig       = frame_trig | line_trig;
    // (pix_y + 1)[0] is simply the inverse of pix_y[0].
    assign trig_buf   = frame_trig ? 1'b0 : ~bus.pix_y[0];
    assign pix_req    = (bus.pix_x != NO_REQ) && (bus.pix_y != NO_REQ);
    assign line_done  = (offset == OFF_W'(H_VALID));
    assign beat_last  = (beat == BEAT_W'(BURST_LEN - 1));
    // The pending slot is consumed at NEXT by a frame restart, or by a line
    // fetch once the current line has fully landed.
    assign pend_take  = (state == NEXT) && pend_vld && (pend_frame || line_done);
    assign wr_en      = (state == RECV) && bus.rd_data_valid;
    assign base_next  = base + ADDR_W'(H_VALID);

    assign bus.rd_req   = rd_req_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.pix_data = pix_data_p1;

    // Fetch FSM, pending-trigger slot and error flag
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            vsync_q    <= 1'b0;
            buf_ok     <= 2'b00;
            pend_vld   <= 1'b0;
            pend_frame <= 1'b0;
            pend_buf   <= 1'b0;
            tgt_buf    <= 1'b0;
            base       <= '0;
            offset     <= '0;
            beat       <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            underrun   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (frame_trig) underrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (trig) begin
                        state           <= REQ;
                        rd_req_q        <= 1'b1;
                        tgt_buf         <= trig_buf;
                        buf_ok[trig_buf] <= 1'b0;
                        offset          <= '0;
                        beat            <= '0;
                        if (frame_trig) begin
                            base      <= '0;
                            rd_addr_q <= '0;
                        end else begin
                            rd_addr_q <= base;
                        end
                    end
                end
                REQ: begin
                    if (bus.rd_ack) begin
                        rd_req_q <= 1'b0;
                        state    <= RECV;
                    end
                end
                RECV: begin
                    if (bus.rd_data_valid) begin
                        offset <= offset + OFF_W'(1);
                        beat   <= beat_last ? '0 : beat + BEAT_W'(1);
                        if (beat_last) state <= NEXT;
                    end
                end
                NEXT: begin
                    if (pend_vld && pend_frame) begin
                        // Drop the partly fetched line and restart the frame.
                        state     <= REQ;
                        rd_req_q  <= 1'b1;
                        tgt_buf   <= 1'b0;
                        buf_ok[0] <= 1'b0;
                        base      <= '0;
                        offset    <= '0;
                        rd_addr_q <= '0;
                    end else if (line_done) begin
                        buf_ok[tgt_buf] <= 1'b1;
                        base            <= base_next;
                        if (pend_vld) begin
                            state            <= REQ;
                            rd_req_q         <= 1'b1;
                            tgt_buf          <= pend_buf;
                            buf_ok[pend_buf] <= 1'b0;
                            offset           <= '0;
                            rd_addr_q        <= base_next;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state     <= REQ;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= base + ADDR_W'(offset);
                    end
                end
                default: state <= IDLE;
            endcase

            if (pend_take) pend_vld <= 1'b0;
            // Triggers that arrive mid-fetch wait in the single slot; a
            // second one before the slot drains means a lost fetch.
            if (trig && (state != IDLE)) begin
                pend_vld   <= 1'b1;
                pend_frame <= frame_trig;
                pend_buf   <= trig_buf;
                if (pend_vld && !pend_take) underrun <= 1'b1;
            end

            if (pix_req && !buf_ok[bus.pix_y[0]]) underrun <= 1'b1;
        end
    end

    // Line buffer write port, fed straight from the read beats
    always_ff @(posedge vga_clk) begin
        if (wr_en) line_buf[tgt_buf][offset[IDX_W-1:0]] <= bus.rd_data;
    end

    // Pixel stage p1: answer registered one clock after the request
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data_p1 <= '0;
        end else if (!pix_req) begin
            pix_data_p1 <= '0;
        end else if (buf_ok[bus.pix_y[0]]) begin
            pix_data_p1 <= line_buf[bus.pix_y[0]][bus.pix_x[IDX_W-1:0]];
        end else begin
            pix_data_p1 <= UNDERRUN_COLOR;
        end
    end
endmodule
